// File: rtl/host_arb_pkg.sv
// host_arb_pkg: shared types and constants for the two-host wishbone arbiter.
//   arb_state_e  - grant state (IDLE / REQ / RSP)
//   HOST0, HOST1 - host port indices, also the encoding of owner/last_owner
//   DCOUNT_W     - width of the data_count fields
package host_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

    localparam logic HOST0 = 1'b0;
    localparam logic HOST1 = 1'b1;

    localparam int DCOUNT_W = 28;

endpackage

// File: rtl/host_arb_rr.sv
// host_arb_rr: two-request round-robin picker.
//   clk, rst    - clock, synchronous active-high reset
//   req0, req1  - host requests
//   done        - strobe: the current transaction finished (final beat or timeout)
//   done_owner  - host that owned the finished transaction
//   winner      - host to grant this cycle (meaningful while any request is high)
//   last_owner  - host that most recently completed a transaction
module host_arb_rr
    import host_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic done,
    input  logic done_owner,
    output logic winner,
    output logic last_owner
);

    logic last_owner_q;
    logic last_owner_d;

    // NOTE: every variable written in an always_comb gets a default first,
    // so no path through the block can infer a latch.
    always_comb begin
        last_owner_d = last_owner_q;
        if (done) begin
            last_owner_d = done_owner;
        end
    end

    // A lone request wins outright; a tie goes to whoever did not finish last.
    always_comb begin
        winner = HOST0;
        unique case ({req1, req0})
            2'b01:   winner = HOST0;
            2'b10:   winner = HOST1;
            2'b11:   winner = ~last_owner_q;
            default: winner = HOST0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    // Starting at HOST1 lets HOST0 win the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= HOST1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    assign last_owner = last_owner_q;

endmodule

// File: rtl/host_arbiter.sv
// host_arbiter: shares one wishbone master command interface between two hosts.
// A grant covers a whole transaction: request beats (REQ) through the final
// response beat (RSP, data_count == 0). Ties alternate round-robin; a grant that
// sees no accepted beat for TIMEOUT_CYCLES cycles is forcibly released.
//   clk, rst                - clock, synchronous active-high reset
//   hX_ih_*/hX_in_*         - host X request beat (reset, valid, fields)
//   hX_master_ready         - master ready, shown to the owner only during REQ
//   hX_oh_ready / hX_oh_en  - host X response handshake
//   o_ih_* / o_in_*         - request forwarded to the master
//   i_master_ready          - master accepts a request beat
//   o_oh_ready / i_oh_en    - response handshake with the master
//   i_out_* / o_out_*       - response fields, fanned out to both hosts
//   o_owner/o_busy/o_timeout- owner, grant active, forced-release pulse
module host_arbiter
    import host_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                h0_ih_reset,
    input  logic                h0_ih_ready,
    input  logic [31:0]         h0_in_command,
    input  logic [31:0]         h0_in_address,
    input  logic [31:0]         h0_in_data,
    input  logic [DCOUNT_W-1:0] h0_in_data_count,
    output logic                h0_master_ready,
    input  logic                h0_oh_ready,
    output logic                h0_oh_en,
    input  logic                h1_ih_reset,
    input  logic                h1_ih_ready,
    input  logic [31:0]         h1_in_command,
    input  logic [31:0]         h1_in_address,
    input  logic [31:0]         h1_in_data,
    input  logic [DCOUNT_W-1:0] h1_in_data_count,
    output logic                h1_master_ready,
    input  logic                h1_oh_ready,
    output logic                h1_oh_en,
    output logic                o_ih_reset,
    output logic                o_ih_ready,
    output logic [31:0]         o_in_command,
    output logic [31:0]         o_in_address,
    output logic [31:0]         o_in_data,
    output logic [DCOUNT_W-1:0] o_in_data_count,
    input  logic                i_master_ready,
    output logic                o_oh_ready,
    input  logic                i_oh_en,
    input  logic [31:0]         i_out_status,
    input  logic [31:0]         i_out_address,
    input  logic [31:0]         i_out_data,
    input  logic [DCOUNT_W-1:0] i_out_data_count,
    output logic [31:0]         o_out_status,
    output logic [31:0]         o_out_address,
    output logic [31:0]         o_out_data,
    output logic [DCOUNT_W-1:0] o_out_data_count,
    output logic                o_owner,
    output logic                o_busy,
    output logic                o_timeout
);

    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    logic        rr_winner;
    logic        rr_last_owner;
    logic        rr_done;

    logic        busy;
    logic        host_rst;
    logic        req_acc;
    logic        rsp_acc;
    logic        final_beat;
    logic        timeout_hit;
    logic [31:0] cnt_inc;

    host_arb_rr u_rr (
        .clk        (clk),
        .rst        (rst),
        .req0       (h0_ih_ready),
        .req1       (h1_ih_ready),
        .done       (rr_done),
        .done_owner (owner_q),
        .winner     (rr_winner),
        .last_owner (rr_last_owner)
    );

    assign busy     = (state_q != IDLE);
    assign host_rst = h0_ih_reset | h1_ih_reset;

    // Owner-side muxing and gating of everything that crosses the arbiter.
    always_comb begin
        o_ih_ready       = 1'b0;
        o_in_command     = '0;
        o_in_address     = '0;
        o_in_data        = '0;
        o_in_data_count  = '0;
        o_oh_ready       = 1'b0;
        h0_master_ready  = 1'b0;
        h1_master_ready  = 1'b0;
        h0_oh_en         = 1'b0;
        h1_oh_en         = 1'b0;
        o_out_status     = '0;
        o_out_address    = '0;
        o_out_data       = '0;
        o_out_data_count = '0;
        if (busy) begin
            o_ih_ready       = (state_q == REQ) &
                               ((owner_q == HOST1) ? h1_ih_ready : h0_ih_ready);
            o_in_command     = (owner_q == HOST1) ? h1_in_command    : h0_in_command;
            o_in_address     = (owner_q == HOST1) ? h1_in_address    : h0_in_address;
            o_in_data        = (owner_q == HOST1) ? h1_in_data       : h0_in_data;
            o_in_data_count  = (owner_q == HOST1) ? h1_in_data_count : h0_in_data_count;
            o_oh_ready       = (owner_q == HOST1) ? h1_oh_ready      : h0_oh_ready;
            // master_ready only means "your request beat goes through", so it
            // is withheld once the request phase is over.
            h0_master_ready  = (state_q == REQ) & (owner_q == HOST0) & i_master_ready;
            h1_master_ready  = (state_q == REQ) & (owner_q == HOST1) & i_master_ready;
            // The first response beat can arrive while still in REQ; the owner
            // sees it there too so no beat is handed to the master unseen.
            h0_oh_en         = (owner_q == HOST0) & i_oh_en;
            h1_oh_en         = (owner_q == HOST1) & i_oh_en;
            o_out_status     = i_out_status;
            o_out_address    = i_out_address;
            o_out_data       = i_out_data;
            o_out_data_count = i_out_data_count;
        end
    end

    assign req_acc     = o_ih_ready & i_master_ready;
    assign rsp_acc     = i_oh_en & o_oh_ready;
    assign final_beat  = rsp_acc & (i_out_data_count == '0);
    assign cnt_inc     = cnt_q + 32'd1;
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without an accepted beat.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_LIMIT);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        rr_done   = 1'b0;
        if (host_rst) begin
            // Abort without touching last_owner: the aborted host did not finish.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (h0_ih_ready | h1_ih_ready) begin
                        owner_d = rr_winner;
                        state_d = REQ;
                    end
                end
                REQ, RSP: begin
                    if (final_beat) begin
                        // Completion wins over a coincident timeout.
                        state_d = IDLE;
                        cnt_d   = '0;
                        rr_done = 1'b1;
                    end else if (req_acc | rsp_acc) begin
                        cnt_d = '0;
                        if (i_oh_en) state_d = RSP;
                    end else if (timeout_hit) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        rr_done   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (i_oh_en) state_d = RSP;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= HOST0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_ih_reset = host_rst;
    assign o_owner    = owner_q;
    assign o_busy     = busy;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_host_arbiter.sv
// tb_host_arbiter: directed bench for host_arbiter with a transaction-level
// model compared on every falling edge, plus hand-computed literal checks.
module tb_host_arbiter;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;

    logic        h_rst [2];
    logic        h_rdy [2];
    logic        h_ohr [2];
    logic [31:0] h_cmd [2];
    logic [31:0] h_addr[2];
    logic [31:0] h_dat [2];
    logic [27:0] h_cnt [2];

    logic        i_mr;
    logic        i_oh_en;
    logic [31:0] i_st, i_ad, i_dt;
    logic [27:0] i_dc;

    logic        h0_master_ready, h1_master_ready, h0_oh_en, h1_oh_en;
    logic        o_ih_reset, o_ih_ready, o_oh_ready;
    logic [31:0] o_in_command, o_in_address, o_in_data;
    logic [27:0] o_in_data_count;
    logic [31:0] o_out_status, o_out_address, o_out_data;
    logic [27:0] o_out_data_count;
    logic        o_owner, o_busy, o_timeout;

    int n_cmp = 0;
    int n_err = 0;

    host_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .h0_ih_reset      (h_rst[0]),
        .h0_ih_ready      (h_rdy[0]),
        .h0_in_command    (h_cmd[0]),
        .h0_in_address    (h_addr[0]),
        .h0_in_data       (h_dat[0]),
        .h0_in_data_count (h_cnt[0]),
        .h0_master_ready  (h0_master_ready),
        .h0_oh_ready      (h_ohr[0]),
        .h0_oh_en         (h0_oh_en),
        .h1_ih_reset      (h_rst[1]),
        .h1_ih_ready      (h_rdy[1]),
        .h1_in_command    (h_cmd[1]),
        .h1_in_address    (h_addr[1]),
        .h1_in_data       (h_dat[1]),
        .h1_in_data_count (h_cnt[1]),
        .h1_master_ready  (h1_master_ready),
        .h1_oh_ready      (h_ohr[1]),
        .h1_oh_en         (h1_oh_en),
        .o_ih_reset       (o_ih_reset),
        .o_ih_ready       (o_ih_ready),
        .o_in_command     (o_in_command),
        .o_in_address     (o_in_address),
        .o_in_data        (o_in_data),
        .o_in_data_count  (o_in_data_count),
        .i_master_ready   (i_mr),
        .o_oh_ready       (o_oh_ready),
        .i_oh_en          (i_oh_en),
        .i_out_status     (i_st),
        .i_out_address    (i_ad),
        .i_out_data       (i_dt),
        .i_out_data_count (i_dc),
        .o_out_status     (o_out_status),
        .o_out_address    (o_out_address),
        .o_out_data       (o_out_data),
        .o_out_data_count (o_out_data_count),
        .o_owner          (o_owner),
        .o_busy           (o_busy),
        .o_timeout        (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_busy/m_rsp: a grant exists / its response has started.
    // m_run: consecutive granted cycles without an accepted beat.
    bit m_busy, m_rsp, m_owner, m_last, m_to;
    int m_run;

    always @(negedge clk) begin
        bit o;
        bit e_mr [2];
        bit e_en [2];
        bit took_req, took_rsp;
        if (rst) begin
            m_busy = 0; m_rsp = 0; m_owner = 0; m_last = 1; m_to = 0; m_run = 0;
        end else begin
            o = m_owner;
            e_mr[0] = 0; e_mr[1] = 0; e_en[0] = 0; e_en[1] = 0;
            if (m_busy) begin
                e_en[o] = i_oh_en;
                if (!m_rsp) e_mr[o] = i_mr;
            end
            check("m_ih_reset", o_ih_reset, h_rst[0] | h_rst[1]);
            check("m_ih_ready", o_ih_ready, (m_busy && !m_rsp) ? h_rdy[o] : 1'b0);
            check("m_in_command", o_in_command, m_busy ? h_cmd[o] : 32'h0);
            check("m_in_address", o_in_address, m_busy ? h_addr[o] : 32'h0);
            check("m_in_data", o_in_data, m_busy ? h_dat[o] : 32'h0);
            check("m_in_data_count", o_in_data_count, m_busy ? h_cnt[o] : 28'h0);
            check("m_oh_ready", o_oh_ready, m_busy ? h_ohr[o] : 1'b0);
            check("m_h0_master_ready", h0_master_ready, e_mr[0]);
            check("m_h1_master_ready", h1_master_ready, e_mr[1]);
            check("m_h0_oh_en", h0_oh_en, e_en[0]);
            check("m_h1_oh_en", h1_oh_en, e_en[1]);
            check("m_out_status", o_out_status, m_busy ? i_st : 32'h0);
            check("m_out_address", o_out_address, m_busy ? i_ad : 32'h0);
            check("m_out_data", o_out_data, m_busy ? i_dt : 32'h0);
            check("m_out_data_count", o_out_data_count, m_busy ? i_dc : 28'h0);
            check("m_owner", o_owner, m_owner);
            check("m_busy", o_busy, m_busy);
            check("m_timeout", o_timeout, m_to);

            m_to = 0;
            if (h_rst[0] || h_rst[1]) begin
                m_busy = 0; m_rsp = 0; m_run = 0;
            end else if (!m_busy) begin
                if (h_rdy[0] || h_rdy[1]) begin
                    m_owner = (h_rdy[0] && h_rdy[1]) ? !m_last : h_rdy[1];
                    m_busy = 1; m_rsp = 0; m_run = 0;
                end
            end else begin
                took_req = !m_rsp && h_rdy[o] && i_mr;
                took_rsp = i_oh_en && h_ohr[o];
                if (took_rsp && i_dc == 0) begin
                    m_busy = 0; m_rsp = 0; m_last = o; m_run = 0;
                end else begin
                    m_run = (took_req || took_rsp) ? 0 : m_run + 1;
                    if (TMO != 0 && m_run == TMO) begin
                        m_busy = 0; m_rsp = 0; m_last = o; m_run = 0; m_to = 1;
                    end else if (i_oh_en) begin
                        m_rsp = 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two response beats (count 1 then 0) to host h; returns in the
    // arbitration cycle right after the final beat.
    task automatic two_beats(input int h);
        h_ohr[h] = 1; i_oh_en = 1; i_dc = 28'd1; i_dt = 32'hD000_0001;
        tick();
        i_dc = 28'd0; i_dt = 32'hD000_0000;
        tick();
        i_oh_en = 0; h_ohr[h] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, limit 100000");
        $fatal(1);
    end

    initial begin
        rst = 1; i_mr = 0; i_oh_en = 0;
        i_st = 32'h0000_0005; i_ad = 32'h0000_1234; i_dt = 32'h0; i_dc = 28'h0;
        for (int h = 0; h < 2; h++) begin
            h_rst[h] = 0; h_rdy[h] = 0; h_ohr[h] = 0;
            h_cmd[h] = 32'(h + 1); h_addr[h] = 32'h10 + 32'(h) * 32'h10;
            h_dat[h] = 32'hA5A5_0000 + 32'(h); h_cnt[h] = 28'(h + 1);
        end
        tick(); tick();
        rst = 0;
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_owner", o_owner, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_ih_ready", o_ih_ready, 0);
        h_rst[0] = 1; #1;
        check("ih_reset_follows", o_ih_reset, 1);
        h_rst[0] = 0; #1;

        // Single host: h0, command 1, address 0x10, two response beats.
        h_rdy[0] = 1;
        tick();
        i_mr = 1; #1;
        check("single_ih_ready", o_ih_ready, 1);
        check("single_cmd", o_in_command, 32'h1);
        check("single_addr", o_in_address, 32'h10);
        check("single_h0_mready", h0_master_ready, 1);
        check("single_h1_mready", h1_master_ready, 0);
        tick();
        h_rdy[0] = 0; i_mr = 0;
        h_ohr[0] = 1; i_oh_en = 1; i_dc = 28'd1; #1;
        check("single_beat1_h0", h0_oh_en, 1);
        check("single_beat1_h1", h1_oh_en, 0);
        tick();
        i_dc = 28'd0; #1;
        check("single_beat2_h0", h0_oh_en, 1);
        check("single_beat2_h1", h1_oh_en, 0);
        check("single_busy_final", o_busy, 1);
        tick();
        i_oh_en = 0; h_ohr[0] = 0; #1;
        check("single_busy_after", o_busy, 0);

        // Tie out of reset: h0 first, h1 next, second tie back to h0.
        rst = 1; tick(); rst = 0;
        h_rdy[0] = 1; h_rdy[1] = 1;
        tick();
        i_mr = 1; #1;
        check("tie1_owner", o_owner, 0);
        check("tie1_h1_mready", h1_master_ready, 0);
        tick();
        h_rdy[0] = 0; i_mr = 0;
        two_beats(0);
        #1;
        check("tie1_arb_cycle_idle", o_busy, 0);
        tick();
        i_mr = 1; #1;
        check("tie2_owner_h1", o_owner, 1);
        check("tie2_h1_mready", h1_master_ready, 1);
        check("tie2_addr", o_in_address, 32'h20);
        tick();
        h_rdy[1] = 0; i_mr = 0;
        two_beats(1);
        h_rdy[0] = 1; h_rdy[1] = 1;
        tick();
        #1;
        check("tie3_owner_h0", o_owner, 0);
        tick();
        h_rdy[0] = 0; h_rdy[1] = 0;
        two_beats(0);

        // Contention: h1 asks while h0 is in its response phase.
        h_rdy[0] = 1;
        tick();
        i_mr = 1;
        tick();
        h_rdy[0] = 0;
        h_ohr[0] = 1; i_oh_en = 1; i_dc = 28'd3;
        tick();
        i_oh_en = 0; h_rdy[1] = 1;
        for (int k = 0; k < 4; k++) begin
            #1; check("cont_h1_blocked", h1_master_ready, 0);
            tick();
        end
        i_oh_en = 1; i_dc = 28'd0; #1;
        check("cont_h1_blocked_final", h1_master_ready, 0);
        tick();
        i_oh_en = 0; h_ohr[0] = 0; #1;
        check("cont_arb_idle", o_busy, 0);
        tick();
        #1;
        check("cont_h1_owner", o_owner, 1);
        check("cont_h1_mready", h1_master_ready, 1);
        tick();
        h_rdy[1] = 0; i_mr = 0;
        two_beats(1);

        // Timeout: h0 request accepted, master never answers.
        h_rdy[0] = 1;
        tick();
        i_mr = 1;
        tick();
        h_rdy[0] = 0; i_mr = 0;
        for (int k = 1; k <= TMO; k++) begin
            #1; check("tmo_wait_pulse", o_timeout, 0);
            check("tmo_wait_busy", o_busy, 1);
            tick();
        end
        #1;
        check("tmo_pulse", o_timeout, 1);
        check("tmo_idle", o_busy, 0);
        tick();
        #1;
        check("tmo_pulse_one_cycle", o_timeout, 0);

        // Host reset during RSP, then rst during REQ.
        h_rdy[1] = 1;
        tick();
        i_mr = 1;
        tick();
        h_rdy[1] = 0; i_mr = 0;
        h_ohr[1] = 1; i_oh_en = 1; i_dc = 28'd2;
        tick();
        i_oh_en = 0; h_rst[1] = 1; #1;
        check("hrst_same_cycle", o_ih_reset, 1);
        check("hrst_still_busy", o_busy, 1);
        tick();
        h_rst[1] = 0; h_ohr[1] = 0; #1;
        check("hrst_idle", o_busy, 0);
        h_rdy[0] = 1; h_rdy[1] = 1;
        tick();
        #1;
        check("hrst_keeps_last_owner", o_owner, 1);
        rst = 1;
        tick();
        rst = 0; i_mr = 1; h_rdy[1] = 0; #1;
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_ih_ready", o_ih_ready, 0);
        check("rst_mid_owner", o_owner, 0);
        check("rst_mid_h0_mready", h0_master_ready, 0);
        check("rst_mid_cmd", o_in_command, 32'h0);
        check("rst_mid_oh_ready", o_oh_ready, 0);

        // Backpressure: beat offered but owner not ready for 5 cycles.
        tick();
        tick();
        h_rdy[0] = 0; i_mr = 0;
        i_oh_en = 1; i_dc = 28'd1; h_ohr[0] = 0;
        for (int k = 1; k <= 5; k++) begin
            #1; check("bp_grant_holds", o_busy, 1);
            check("bp_owner", o_owner, 0);
            check("bp_oh_en_shown", h0_oh_en, 1);
            tick();
        end
        i_oh_en = 0;
        for (int k = 6; k <= TMO; k++) begin
            #1; check("bp_no_early_timeout", o_timeout, 0);
            tick();
        end
        #1;
        check("bp_counter_advanced", o_timeout, 1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
